// File: rtl/xor_frame_checksum.sv
`default_nettype none
// ============================================================================
// Module      : xor_frame_checksum
// Description : Folds a framed byte stream into an XOR checksum and beat count,
//               presenting each frame result through a one-deep output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_frame_checksum #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [W-1:0]     io_in_bits,
  input  logic             io_in_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [W-1:0]     io_out_bits,
  output logic [CNT_W-1:0] io_out_count,
  output logic             io_out_sat,
  output logic             io_out_zero,
  output logic             io_busy
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [0:0] {S_IDLE  = 1'b0, S_ACCUM = 1'b1} frame_state_t;
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL  = 1'b1} out_state_t;

  frame_state_t r_frame_state, w_frame_next;
  out_state_t   r_out_state,   w_out_next;

  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat_acc;
  logic [W-1:0]     r_out_bits;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_sat;
  logic             r_out_zero;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_last_fire;
  logic             w_body_fire;
  logic             w_cnt_full;
  logic [W-1:0]     w_acc_next;
  logic [CNT_W-1:0] w_cnt_inc;

  // The slot can refill in the same cycle it drains, so ready looks through to the consumer.
  assign io_out_valid = (r_out_state == S_FULL);
  assign io_in_ready  = !io_out_valid | io_out_ready;
  assign io_busy      = (r_frame_state == S_ACCUM);

  assign w_in_fire   = io_in_valid & io_in_ready;
  assign w_out_fire  = io_out_valid & io_out_ready;
  assign w_last_fire = w_in_fire & io_in_last;
  assign w_body_fire = w_in_fire & !io_in_last;
  assign w_cnt_full  = (r_cnt == c_cnt_max);
  assign w_acc_next  = r_acc ^ io_in_bits;
  assign w_cnt_inc   = w_cnt_full ? c_cnt_max : r_cnt + 1'b1;

  assign io_out_bits  = r_out_bits;
  assign io_out_count = r_out_count;
  assign io_out_sat   = r_out_sat;
  assign io_out_zero  = r_out_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_state <= S_IDLE;
      r_out_state   <= S_EMPTY;
    end else begin
      r_frame_state <= w_frame_next;
      r_out_state   <= w_out_next;
    end
  end

  always_comb begin
    w_frame_next = r_frame_state;
    w_out_next   = r_out_state;
    case (r_frame_state)
      S_IDLE:  if (w_body_fire) w_frame_next = S_ACCUM;
      S_ACCUM: if (w_last_fire) w_frame_next = S_IDLE;
      default: w_frame_next = S_IDLE;
    endcase
    case (r_out_state)
      S_EMPTY: if (w_last_fire) w_out_next = S_FULL;
      S_FULL:  if (w_out_fire && !w_last_fire) w_out_next = S_EMPTY;
      default: w_out_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat_acc   <= 1'b0;
      r_out_bits  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else if (w_last_fire) begin
      r_out_bits  <= w_acc_next;
      r_out_count <= w_cnt_inc;
      r_out_sat   <= r_sat_acc | w_cnt_full;
      r_out_zero  <= (w_acc_next == '0);
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat_acc   <= 1'b0;
    end else if (w_body_fire) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_inc;
      if (w_cnt_full) r_sat_acc <= 1'b1;
    end
  end

endmodule
`default_nettype wire
